dualshock2_pad: RTL and testbench

//  Device-side (controller) end of the PSX/DualShock2 serial link: emulates a pad answering a host.

---
 rtl/dualshock2_pad.sv | 207 ++++++++++++++++++++
 tb/tb_dualshock2_pad.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dualshock2_pad.sv
// Device-side PSX/DualShock2 pad: answers host poll (0x42), config (0x43) and set-mode (0x44) frames.
// Latency: 2-FF pin sync plus one registered stage, so reactions land 2-3 clk after a pin edge.
// Backpressure: none; the host paces bytes with CLK and waits for ACK, which is skipped on the last byte or after a reject.
module dualshock2_pad #(
    parameter bit ANALOG_DEFAULT = 1'b0,
    parameter int ACK_DELAY      = 16,
    parameter int ACK_WIDTH      = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ds2_att,
    input  logic        ds2_clk,
    input  logic        ds2_cmd,
    output logic        ds2_dat,
    output logic        ds2_ack,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_rx,
    input  logic [7:0]  stick_ry,
    input  logic [7:0]  stick_lx,
    input  logic [7:0]  stick_ly,
    output logic        analog_mode,
    output logic        config_mode,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT, ST_ACK_WAIT, ST_ACK_LOW, ST_DONE, ST_REJECT
    } state_t;

    state_t      state_q;
    logic [1:0]  att_sync_q, clk_sync_q, cmd_sync_q;
    logic        att_prev_q, clk_prev_q;
    logic        dat_q, ack_q, frame_done_q, config_q, analog_q, param_q;
    logic [3:0]  byte_idx_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  rx_q, cmd_q;
    logic [15:0] cnt_q;
    logic [15:0] btn_q;
    logic [7:0]  rx_snap_q, ry_snap_q, lx_snap_q, ly_snap_q;

    logic        att_s, clk_s, cmd_s;
    logic        att_fall, att_rise, clk_fall, clk_rise;
    logic [7:0]  tx_byte, rx_next;
    logic [3:0]  last_idx;
    logic        cmd_ok;

    assign att_s    = att_sync_q[1];
    assign clk_s    = clk_sync_q[1];
    assign cmd_s    = cmd_sync_q[1];
    assign att_fall = att_prev_q & ~att_s;
    assign att_rise = ~att_prev_q & att_s;
    assign clk_fall = clk_prev_q & ~clk_s;
    assign clk_rise = ~clk_prev_q & clk_s;

    assign ds2_dat     = dat_q;
    assign ds2_ack     = ack_q;
    assign frame_done  = frame_done_q;
    assign config_mode = config_q;
    assign analog_mode = analog_q;

    // Mode is fixed for the whole frame (it only changes at ATT rise), so length is too
    assign last_idx = (analog_q | config_q) ? 4'd8 : 4'd4;

    // Received byte including the bit arriving on this CLK rise
    always_comb begin
        rx_next            = rx_q;
        rx_next[bit_idx_q] = cmd_s;
    end

    // 0x44 is only honoured from config mode
    assign cmd_ok = (rx_next == 8'h42) || (rx_next == 8'h43) ||
                    (config_q && (rx_next == 8'h44));

    // Reply byte for the current position in the frame
    always_comb begin
        tx_byte = 8'hFF;
        case (byte_idx_q)
            4'd0:    tx_byte = 8'hFF;
            4'd1:    tx_byte = config_q ? 8'hF3 : (analog_q ? 8'h73 : 8'h41);
            4'd2:    tx_byte = 8'h5A;
            4'd3:    tx_byte = config_q ? 8'h00 : ~btn_q[7:0];
            4'd4:    tx_byte = config_q ? 8'h00 : ~btn_q[15:8];
            4'd5:    tx_byte = config_q ? 8'h00 : rx_snap_q;
            4'd6:    tx_byte = config_q ? 8'h00 : ry_snap_q;
            4'd7:    tx_byte = config_q ? 8'h00 : lx_snap_q;
            4'd8:    tx_byte = config_q ? 8'h00 : ly_snap_q;
            default: tx_byte = 8'hFF;
        endcase
    end

    // Two-flop synchronisers and previous-value registers for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            att_sync_q <= 2'b11;
            clk_sync_q <= 2'b11;
            cmd_sync_q <= 2'b00;
            att_prev_q <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            att_sync_q <= {att_sync_q[0], ds2_att};
            clk_sync_q <= {clk_sync_q[0], ds2_clk};
            cmd_sync_q <= {cmd_sync_q[0], ds2_cmd};
            att_prev_q <= att_s;
            clk_prev_q <= clk_s;
        end
    end

    // Frame FSM: bit shifting, ACK timing, command validation and mode updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dat_q        <= 1'b1;
            ack_q        <= 1'b1;
            frame_done_q <= 1'b0;
            config_q     <= 1'b0;
            analog_q     <= ANALOG_DEFAULT;
            param_q      <= 1'b0;
            byte_idx_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            rx_q         <= 8'h00;
            cmd_q        <= 8'h00;
            cnt_q        <= 16'd0;
            btn_q        <= 16'd0;
            rx_snap_q    <= 8'h80;
            ry_snap_q    <= 8'h80;
            lx_snap_q    <= 8'h80;
            ly_snap_q    <= 8'h80;
        end else begin
            frame_done_q <= 1'b0;
            if (state_q != ST_IDLE && att_rise) begin
                // Host ended the frame; mode changes only stick if every byte was exchanged
                state_q <= ST_IDLE;
                dat_q   <= 1'b1;
                ack_q   <= 1'b1;
                if (state_q == ST_DONE) begin
                    frame_done_q <= 1'b1;
                    if (cmd_q == 8'h43) config_q <= param_q;
                    if (cmd_q == 8'h44) analog_q <= param_q;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (att_fall) begin
                            btn_q      <= buttons;
                            rx_snap_q  <= stick_rx;
                            ry_snap_q  <= stick_ry;
                            lx_snap_q  <= stick_lx;
                            ly_snap_q  <= stick_ly;
                            byte_idx_q <= 4'd0;
                            bit_idx_q  <= 3'd0;
                            state_q    <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_fall) begin
                            dat_q <= tx_byte[bit_idx_q];
                        end else if (clk_rise) begin
                            rx_q <= rx_next;
                            if (bit_idx_q == 3'd7) begin
                                bit_idx_q <= 3'd0;
                                dat_q     <= 1'b1;
                                if (byte_idx_q == 4'd1) cmd_q   <= rx_next;
                                if (byte_idx_q == 4'd3) param_q <= rx_next[0];
                                if (byte_idx_q == 4'd0 && rx_next != 8'h01) begin
                                    state_q <= ST_REJECT;
                                end else if (byte_idx_q == 4'd1 && !cmd_ok) begin
                                    state_q <= ST_REJECT;
                                end else if (byte_idx_q == last_idx) begin
                                    state_q <= ST_DONE;
                                end else begin
                                    state_q <= ST_ACK_WAIT;
                                    cnt_q   <= 16'(ACK_DELAY - 1);
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end
                    ST_ACK_WAIT: begin
                        if (cnt_q == 16'd0) begin
                            ack_q   <= 1'b0;
                            cnt_q   <= 16'(ACK_WIDTH - 1);
                            state_q <= ST_ACK_LOW;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_ACK_LOW: begin
                        if (cnt_q == 16'd0) begin
                            ack_q      <= 1'b1;
                            byte_idx_q <= byte_idx_q + 4'd1;
                            state_q    <= ST_SHIFT;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_DONE, ST_REJECT: begin
                        dat_q <= 1'b1;
                        ack_q <= 1'b1;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dualshock2_pad.sv
// Directed host-side bench for the DualShock2 pad emulation.
// Host bit clock is 20 clk per bit; ACK is waited on with bounded loops.
// Expected reply bytes are hand-derived from the pad protocol.
module tb_dualshock2_pad;

    localparam int ACK_D = 16;
    localparam int ACK_W = 300;

    typedef logic [7:0] vec_t [9];

    logic        clk = 1'b0;
    logic        rst;
    logic        ds2_att, ds2_clk, ds2_cmd;
    logic        ds2_dat, ds2_ack;
    logic [15:0] buttons;
    logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly;
    logic        analog_mode, config_mode, frame_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   fd_cnt = 0;
    int   ack_cnt = 0;
    logic ack_prev = 1'b1;
    vec_t tx, ex;

    always #5 clk = ~clk;

    dualshock2_pad #(.ANALOG_DEFAULT(1'b0), .ACK_DELAY(ACK_D), .ACK_WIDTH(ACK_W)) dut (
        .clk(clk), .rst(rst),
        .ds2_att(ds2_att), .ds2_clk(ds2_clk), .ds2_cmd(ds2_cmd),
        .ds2_dat(ds2_dat), .ds2_ack(ds2_ack),
        .buttons(buttons),
        .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx), .stick_ly(stick_ly),
        .analog_mode(analog_mode), .config_mode(config_mode), .frame_done(frame_done)
    );

    // Count ACK falling edges and frame_done pulses
    always @(posedge clk) begin
        ack_prev <= ds2_ack;
        if (ack_prev && !ds2_ack) ack_cnt <= ack_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            ds2_clk = 1'b0;
            ds2_cmd = b[i];
            cyc(10);
            rx[i]   = ds2_dat;
            ds2_clk = 1'b1;
            cyc(10);
        end
    endtask

    task automatic wait_ack_low(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (!ds2_ack) seen = 1'b1;
            else cyc(1);
        end
    endtask

    task automatic host_byte(input logic [7:0] b, input bit want_ack, input string tag,
                             output logic [7:0] rx);
        bit seen;
        host_bits(b, 8, rx);
        wait_ack_low(seen);
        chk($sformatf("%s ack", tag), {31'd0, seen}, {31'd0, want_ack});
        if (seen) begin
            for (int i = 0; i < ACK_W + 20 && !ds2_ack; i++) cyc(1);
            chk($sformatf("%s ack release", tag), {31'd0, ds2_ack}, 32'd1);
        end
    endtask

    task automatic run_frame(input string tag, input vec_t t, input vec_t e, input int n,
                             input int n_ack, input int exp_done);
        int fd0, ak0;
        logic [7:0] rx;
        fd0 = fd_cnt;
        ak0 = ack_cnt;
        ds2_att = 1'b0;
        cyc(10);
        for (int i = 0; i < n; i++) begin
            host_byte(t[i], i < n_ack, $sformatf("%s b%0d", tag, i), rx);
            chk($sformatf("%s dat%0d", tag, i), {24'd0, rx}, {24'd0, e[i]});
        end
        ds2_att = 1'b1;
        cyc(10);
        chk($sformatf("%s ack count", tag), ack_cnt - ak0, n_ack);
        chk($sformatf("%s frame_done", tag), fd_cnt - fd0, exp_done);
    endtask

    initial begin
        logic [7:0] rx;
        bit seen;
        int fd0;
        rst = 1'b1;
        ds2_att = 1'b1; ds2_clk = 1'b1; ds2_cmd = 1'b1;
        buttons = 16'h0000;
        stick_rx = 8'h80; stick_ry = 8'h80; stick_lx = 8'h80; stick_ly = 8'h80;
        cyc(3);
        chk("reset dat", {31'd0, ds2_dat}, 32'd1);
        chk("reset ack", {31'd0, ds2_ack}, 32'd1);
        chk("reset analog", {31'd0, analog_mode}, 32'd0);
        chk("reset config", {31'd0, config_mode}, 32'd0);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        cyc(5);

        // Digital poll
        buttons = 16'h0011;
        tx = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'h41, 8'h5A, 8'hEE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("dig poll", tx, ex, 5, 4, 1);

        // Enter config from digital
        buttons = 16'h0000;
        tx = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("cfg enter", tx, ex, 5, 4, 1);
        chk("cfg enter config_mode", {31'd0, config_mode}, 32'd1);

        // Set analog while in config
        tx = '{8'h01, 8'h44, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'hF3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("set analog", tx, ex, 9, 8, 1);
        chk("set analog analog_mode", {31'd0, analog_mode}, 32'd1);

        // Exit config
        tx = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("cfg exit", tx, ex, 9, 8, 1);
        chk("cfg exit config_mode", {31'd0, config_mode}, 32'd0);

        // Analog poll with sticks
        stick_rx = 8'h80; stick_ry = 8'h7F; stick_lx = 8'h10; stick_ly = 8'hF0;
        tx = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h10, 8'hF0};
        run_frame("ana poll", tx, ex, 9, 8, 1);

        // Bad first byte: reject, DAT stays high
        tx = '{8'h81, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("rej byte0", tx, ex, 5, 0, 0);

        // 0x44 outside config: ID then reject, mode unchanged
        tx = '{8'h01, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'h73, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("rej 44", tx, ex, 5, 1, 0);
        chk("rej 44 analog_mode", {31'd0, analog_mode}, 32'd1);

        // Abort after bit 3 of byte 2 of a config-enter frame
        fd0 = fd_cnt;
        ds2_att = 1'b0;
        cyc(10);
        host_byte(8'h01, 1'b1, "abort b0", rx);
        chk("abort dat0", {24'd0, rx}, 32'hFF);
        host_byte(8'h43, 1'b1, "abort b1", rx);
        chk("abort dat1", {24'd0, rx}, 32'h73);
        host_bits(8'h00, 4, rx);
        chk("abort dat2 low nibble", {28'd0, rx[3:0]}, 32'hA);
        ds2_att = 1'b1;
        cyc(3);
        chk("abort dat idle", {31'd0, ds2_dat}, 32'd1);
        chk("abort ack idle", {31'd0, ds2_ack}, 32'd1);
        cyc(10);
        chk("abort config_mode", {31'd0, config_mode}, 32'd0);
        chk("abort frame_done", fd_cnt - fd0, 32'd0);

        // Abort while ACK is low
        ds2_att = 1'b0;
        cyc(10);
        host_byte(8'h01, 1'b1, "ackabort b0", rx);
        host_bits(8'h42, 8, rx);
        chk("ackabort id", {24'd0, rx}, 32'h73);
        wait_ack_low(seen);
        chk("ackabort ack low", {31'd0, seen}, 32'd1);
        ds2_att = 1'b1;
        cyc(3);
        chk("ackabort ack released", {31'd0, ds2_ack}, 32'd1);
        cyc(10);

        // Reset mid-frame during ACK
        ds2_att = 1'b0;
        cyc(10);
        host_bits(8'h01, 8, rx);
        wait_ack_low(seen);
        chk("rst ack low", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        cyc(1);
        chk("rst ack", {31'd0, ds2_ack}, 32'd1);
        chk("rst dat", {31'd0, ds2_dat}, 32'd1);
        chk("rst analog", {31'd0, analog_mode}, 32'd0);
        rst = 1'b0;
        ds2_att = 1'b1;
        cyc(10);

        // Digital poll after reset, different button pattern
        buttons = 16'hA55A;
        tx = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex = '{8'hFF, 8'h41, 8'h5A, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("post rst poll", tx, ex, 5, 4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
